// File: rtl/bcd_count_pkg.sv
// Shared types and helpers for the cascaded BCD counter controller.
// Holds the FSM state type, digit constants and the chain increment model.
package bcd_count_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned MAX_DIGITS = 8;
    localparam logic [3:0]  BCD_MAX    = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic        wrap;
        logic [31:0] value;
    } bcd_inc_t;

    // Next value of a chain of 'digits' decades; digits above 'digits' pass through.
    function automatic bcd_inc_t bcd_inc_chain(input logic [31:0] cnt,
                                               input int unsigned digits);
        bcd_inc_t r;
        logic     carry;
        r.value = cnt;
        carry   = 1'b1;
        for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
            if (k < digits && carry) begin
                if (cnt[k*BCD_W +: BCD_W] == BCD_MAX) begin
                    r.value[k*BCD_W +: BCD_W] = '0;
                end else begin
                    r.value[k*BCD_W +: BCD_W] = cnt[k*BCD_W +: BCD_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        r.wrap = carry;
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade counter digit: synchronous clear, enable-gated increment,
// terminal-count flag when the digit holds 9.
module bcd_digit
    import bcd_count_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] q,
    output logic       tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
        end
    end

    assign tc = (q == BCD_MAX);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run/hold/clear sequencer for a chain of decade digits with a prescaled
// count tick, programmable BCD terminal value and sticky wrap flag.
module bcd_count_ctrl
    import bcd_count_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic [4*DIGITS-1:0] limit,
    output logic [4*DIGITS-1:0] count,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    state_t            state, state_nxt;
    logic [PW-1:0]     presc;
    logic [DIGITS-1:0] tc, en;
    logic              tick, carry_out, match;
    bcd_inc_t          nxt;

    assign tick = (state == RUN) && !clear && !stop && (presc == PMAX);

    always_comb begin
        en[0] = tick;
        for (int unsigned k = 1; k < DIGITS; k++) begin
            en[k] = en[k-1] & tc[k-1];
        end
    end

    assign carry_out = en[DIGITS-1] & tc[DIGITS-1];

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .clk (clk),
                .rst (rst),
                .en  (en[g]),
                .clr (clear),
                .q   (count[g*4 +: 4]),
                .tc  (tc[g])
            );
        end
    endgenerate

    // The ripple carry-out of the digit chain and the chain model must agree
    // on a wrap; a limit digit above 9 can never equal a real digit.
    assign nxt   = bcd_inc_chain(32'(count), DIGITS);
    assign match = (nxt.value == 32'(limit)) && (nxt.wrap == carry_out);

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start && !stop) state_nxt = RUN;
                RUN:     if (stop) state_nxt = HOLD;
                         else if (tick && match) state_nxt = DONE;
                HOLD:    if (start && !stop) state_nxt = RUN;
                DONE:    if (start) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            presc    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= tick && match;
            if (clear) begin
                presc    <= '0;
                overflow <= 1'b0;
            end else begin
                if (state == RUN && !stop) begin
                    presc <= (presc == PMAX) ? '0 : presc + 1'b1;
                end
                if (carry_out) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule
